packet_mem_rd_resp: RTL and testbench

//  Responder side of the controller's packet-memory read request (packet_mem_rd_en + transfer_sz).

---
 rtl/packet_mem_rd_resp.sv | 153 +++++++++++++++
 tb/tb_packet_mem_rd_resp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_mem_rd_resp.sv
// Load responder for the packet buffer: byte/half/word big-endian reads at any byte address,
// split into two word reads when the access straddles a word boundary.
module packet_mem_rd_resp #(
    parameter int PKT_ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [PKT_ADDR_WIDTH-1:0]   rd_addr,
    input  logic [1:0]                  transfer_sz,
    input  logic [PKT_ADDR_WIDTH:0]     pkt_len,
    output logic                        mem_rd_en,
    output logic [PKT_ADDR_WIDTH-3:0]   mem_addr,
    input  logic [31:0]                 mem_rdata,
    output logic                        busy,
    output logic                        resp_valid,
    output logic [31:0]                 resp_data,
    output logic                        resp_err
);

    localparam int WAW = PKT_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, RESP} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       off_reg, off_next;
    logic [1:0]       size_reg, size_next;
    logic [WAW-1:0]   word_reg, word_next;
    logic             span_reg, span_next;
    logic [31:0]      w0_reg, w0_next;
    logic [31:0]      resp_data_reg, resp_data_next;
    logic             resp_err_reg, resp_err_next;

    logic             mem_rd_en_c;
    logic [WAW-1:0]   mem_addr_c;

    logic [2:0]                 req_nbytes;
    logic [PKT_ADDR_WIDTH:0]    req_end;
    logic                       req_err;
    logic                       req_span;

    // Left-align the addressed bytes in the 64-bit window, then right-justify by size.
    function automatic logic [31:0] format_load(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [63:0] s;
        s = {w0, w1} << {off, 3'b000};
        case (size)
            2'b00:   return s[63:32];
            2'b01:   return {16'b0, s[63:48]};
            2'b10:   return {24'b0, s[63:56]};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        case (transfer_sz)
            2'b00:   req_nbytes = 3'd4;
            2'b01:   req_nbytes = 3'd2;
            2'b10:   req_nbytes = 3'd1;
            default: req_nbytes = 3'd0;
        endcase
    end

    // Bounds check is done one bit wider than the address so rd_addr+nbytes cannot wrap.
    assign req_end  = {1'b0, rd_addr} + {{(PKT_ADDR_WIDTH-2){1'b0}}, req_nbytes};
    assign req_err  = (transfer_sz == 2'b11) || (req_end > pkt_len);
    assign req_span = ({1'b0, rd_addr[1:0]} + req_nbytes) > 3'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            off_reg       <= 2'b0;
            size_reg      <= 2'b0;
            word_reg      <= '0;
            span_reg      <= 1'b0;
            w0_reg        <= 32'h0;
            resp_data_reg <= 32'h0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            off_reg       <= off_next;
            size_reg      <= size_next;
            word_reg      <= word_next;
            span_reg      <= span_next;
            w0_reg        <= w0_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        off_next       = off_reg;
        size_next      = size_reg;
        word_next      = word_reg;
        span_next      = span_reg;
        w0_next        = w0_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        mem_rd_en_c    = 1'b0;
        mem_addr_c     = word_reg;

        case (state_reg)
            IDLE: begin
                if (rd_en) begin
                    off_next  = rd_addr[1:0];
                    size_next = transfer_sz;
                    word_next = rd_addr[PKT_ADDR_WIDTH-1:2];
                    span_next = req_span;
                    if (req_err) begin
                        resp_data_next = 32'h0;
                        resp_err_next  = 1'b1;
                        state_next     = RESP;
                    end else begin
                        mem_rd_en_c = 1'b1;
                        mem_addr_c  = rd_addr[PKT_ADDR_WIDTH-1:2];
                        state_next  = WAIT1;
                    end
                end
            end
            WAIT1: begin
                w0_next = mem_rdata;
                if (span_reg) begin
                    mem_rd_en_c = 1'b1;
                    mem_addr_c  = word_reg + 1'b1;
                    state_next  = WAIT2;
                end else begin
                    resp_data_next = format_load(mem_rdata, 32'h0, off_reg, size_reg);
                    resp_err_next  = 1'b0;
                    state_next     = RESP;
                end
            end
            WAIT2: begin
                resp_data_next = format_load(w0_reg, mem_rdata, off_reg, size_reg);
                resp_err_next  = 1'b0;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The accept-cycle strobe is combinational from rd_en, so it is gated off during reset.
    assign mem_rd_en  = mem_rd_en_c & rst;
    assign mem_addr   = mem_addr_c;
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_packet_mem_rd_resp.sv
// Bench for packet_mem_rd_resp: spec vector table, hand-written corner sequences and
// randomized requests checked against a byte-level reference model.
module tb_packet_mem_rd_resp;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    transfer_sz;
    logic [AW:0]   pkt_len;
    logic          mem_rd_en;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic          resp_err;

    packet_mem_rd_resp #(.PKT_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .transfer_sz (transfer_sz),
        .pkt_len     (pkt_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [9:0]  rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // One-cycle-latency packet memory plus a log of every read issued.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            rd_q.push_back(mem_addr);
        end
        if (rst && busy && rd_en)
            $display("note: rd_en while busy at %0t (protocol violation, must be ignored)", $time);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input int a);
        logic [31:0] w;
        w = mem[a / 4];
        return 8'(w >> (8 * (3 - (a % 4))));
    endfunction

    // Reference: gather the addressed bytes big-endian; latency/reads from alignment.
    function automatic void model(input int addr, input int sz, input int plen,
                                  output logic [31:0] data, output bit err,
                                  output int lat, output int nreads);
        int n;
        n = (sz == 0) ? 4 : (sz == 1) ? 2 : (sz == 2) ? 1 : 0;
        err = (sz == 3) || (addr + n > plen);
        data = 32'h0;
        if (err) begin
            lat = 1;
            nreads = 0;
        end else begin
            for (int i = 0; i < n; i++)
                data = (data << 8) | {24'h0, byte_at(addr + i)};
            if ((addr % 4) + n > 4) begin
                lat = 3;
                nreads = 2;
            end else begin
                lat = 2;
                nreads = 1;
            end
        end
    endfunction

    task automatic run_req(input int addr, input int sz, input int plen,
                           input logic [31:0] ed, input bit ee, input int el, input int en,
                           input bit poke);
        int  lat;
        bit  seen;
        @(negedge clk);
        rd_q.delete();
        rd_addr     = addr[AW-1:0];
        transfer_sz = sz[1:0];
        pkt_len     = plen[AW:0];
        rd_en       = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_after_accept", {31'h0, busy}, 32'd1);
            if (poke && lat == 1) begin
                rd_en = 1'b1;
                rd_addr = '0;
                transfer_sz = 2'b10;
            end
            if (poke && lat == 2) rd_en = 1'b0;
            if (resp_valid) seen = 1'b1;
        end
        $display("req addr=%0d sz=%0d len=%0d -> data=%h err=%0b lat=%0d reads=%0d (want %h/%0b/%0d/%0d)",
                 addr, sz, plen, resp_data, resp_err, lat, rd_q.size(), ed, ee, el, en);
        chk("resp_seen", {31'h0, seen}, 32'd1);
        chk("latency", lat, el);
        chk("resp_data", resp_data, ed);
        chk("resp_err", {31'h0, resp_err}, {31'h0, ee});
        chk("num_reads", rd_q.size(), en);
        if (en >= 1 && rd_q.size() >= 1) chk("read_addr0", {22'h0, rd_q[0]}, 32'(addr >> 2));
        if (en == 2 && rd_q.size() >= 2) chk("read_addr1", {22'h0, rd_q[1]}, 32'((addr >> 2) + 1));
    endtask

    typedef struct {
        int          addr;
        int          sz;
        int          plen;
        logic [31:0] data;
        bit          err;
        int          lat;
        int          nreads;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        bit ee;
        int el, en;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'h11223344;
        mem[1]    = 32'h55667788;
        mem[1023] = 32'hA1B2C3D4;

        tbl[0]  = '{0,    0, 8,    32'h11223344, 1'b0, 2, 1};
        tbl[1]  = '{2,    0, 8,    32'h33445566, 1'b0, 3, 2};
        tbl[2]  = '{3,    1, 8,    32'h00004455, 1'b0, 3, 2};
        tbl[3]  = '{6,    2, 8,    32'h00000077, 1'b0, 2, 1};
        tbl[4]  = '{5,    0, 8,    32'h0,        1'b1, 1, 0};
        tbl[5]  = '{0,    3, 8,    32'h0,        1'b1, 1, 0};
        tbl[6]  = '{4,    0, 8,    32'h55667788, 1'b0, 2, 1};
        tbl[7]  = '{6,    1, 8,    32'h00007788, 1'b0, 2, 1};
        tbl[8]  = '{7,    2, 7,    32'h0,        1'b1, 1, 0};
        tbl[9]  = '{0,    0, 0,    32'h0,        1'b1, 1, 0};
        tbl[10] = '{0,    2, 0,    32'h0,        1'b1, 1, 0};
        tbl[11] = '{4092, 0, 4096, 32'hA1B2C3D4, 1'b0, 2, 1};
        tbl[12] = '{4095, 1, 4096, 32'h0,        1'b1, 1, 0};
        tbl[13] = '{4095, 2, 4096, 32'h000000D4, 1'b0, 2, 1};
        tbl[14] = '{1,    1, 8,    32'h00002233, 1'b0, 2, 1};
        tbl[15] = '{3,    0, 8,    32'h44556677, 1'b0, 3, 2};

        rst = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        transfer_sz = 2'b00;
        pkt_len = 13'd8;
        #1;
        chk("reset_busy",       {31'h0, busy},       32'd0);
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("reset_resp_data",  resp_data,           32'd0);
        chk("reset_resp_err",   {31'h0, resp_err},   32'd0);
        chk("reset_mem_rd_en",  {31'h0, mem_rd_en},  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Table vectors, issued back-to-back (each lands in the first IDLE cycle after RESP).
        for (int i = 0; i < 16; i++)
            run_req(tbl[i].addr, tbl[i].sz, tbl[i].plen, tbl[i].data, tbl[i].err,
                    tbl[i].lat, tbl[i].nreads, 1'b0);

        // rd_en pulsed during WAIT1 must not create a second request.
        run_req(2, 0, 8, 32'h33445566, 1'b0, 3, 2, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_resp", {31'h0, resp_valid}, 32'd0);
        end
        chk("no_extra_reads", rd_q.size(), 2);
        chk("hold_resp_data", resp_data, 32'h33445566);

        // Randomized requests against the reference model.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int i = 0; i < 200; i++) begin
            int a, s, l;
            a = $urandom_range(0, 60);
            s = $urandom_range(0, 3);
            l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 64);
            model(a, s, l, ed, ee, el, en);
            run_req(a, s, l, ed, ee, el, en, 1'b0);
        end

        // Reset in WAIT2 abandons the request; the next request completes.
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        run_req(0, 0, 8, 32'h11223344, 1'b0, 2, 1, 1'b0);
        @(negedge clk);
        rd_addr = 12'd2;
        transfer_sz = 2'b00;
        pkt_len = 13'd8;
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_in_wait2", {31'h0, busy}, 32'd1);
        rst = 1'b0;
        rd_en = 1'b1;
        #1;
        chk("rst_busy",       {31'h0, busy},       32'd0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_data",  resp_data,           32'd0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'd0);
        chk("rst_mem_rd_en",  {31'h0, mem_rd_en},  32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp",  {31'h0, resp_valid}, 32'd0);
            chk("rst_no_read",  {31'h0, mem_rd_en},  32'd0);
        end
        rd_en = 1'b0;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abandoned_no_resp", {31'h0, resp_valid}, 32'd0);
        end
        run_req(2, 0, 8, 32'h33445566, 1'b0, 3, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
